// File: rtl/fifo_byte_serializer.sv
// Pops whole words from a show-ahead FIFO and emits them as OutWidth-wide beats, LSB first.
// Holds at most one word at a time and reloads with zero bubble on the last beat.
module fifo_byte_serializer #(
  parameter int DataWidth = 32,
  parameter int OutWidth  = 8,
  parameter int CntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 empty,
  input  logic [DataWidth-1:0] readData,
  output logic                 readEn,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [OutWidth-1:0]  outData,
  output logic                 outLast,
  output logic [CntWidth-1:0]  wordCnt
);

  localparam int Ratio = DataWidth / OutWidth;
  localparam int IdxW  = $clog2(Ratio);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  shreg_q, shreg_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  xfer;

  assign outValid = (state_q == SHIFT);
  assign outData  = shreg_q[OutWidth-1:0];
  assign outLast  = outValid && (idx_q == IdxW'(Ratio - 1));
  assign xfer     = outValid && outReady;
  // Fetch when empty-handed, or when the last beat leaves this cycle.
  assign readEn   = !rst && enable && !empty && ((state_q == IDLE) || (xfer && outLast));
  assign wordCnt  = cnt_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (xfer && outLast) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = IDLE;
    end
    if (readEn) begin
      shreg_d = readData;
      idx_d   = '0;
      state_d = SHIFT;
    end else if (xfer) begin
      shreg_d = shreg_q >> OutWidth;
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/fifo_byte_serializer.md
FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning the FIFO word width.
REQ-002 The block SHALL have parameter OutWidth, default 8, meaning the output beat width; DataWidth SHALL be an integer multiple of OutWidth, with Ratio = DataWidth/OutWidth >= 2.
REQ-003 The block SHALL have parameter CntWidth, default 16, meaning the width of the word counter.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  permits fetching new words from the FIFO.
REQ-007 empty  input  1  FIFO empty flag.
REQ-008 readData  input  DataWidth  FIFO head word, valid in the same cycle as readEn.
REQ-009 readEn  output  1  FIFO pop strobe.
REQ-010 outValid  output  1  output beat valid.
REQ-011 outReady  input  1  downstream accepts the beat.
REQ-012 outData  output  OutWidth  output beat.
REQ-013 outLast  output  1  marks the final beat of a word.
REQ-014 wordCnt  output  CntWidth  count of fully emitted words.

Function
REQ-015 The state machine SHALL have two states: IDLE (no word held) and SHIFT (word held in the shift register, beats pending).
REQ-016 readEn SHALL be asserted combinationally iff !rst && enable && !empty && (state==IDLE || (outValid && outReady && outLast)).
REQ-017 readEn SHALL never be asserted while empty=1.
REQ-018 readEn SHALL never be asserted while rst=1.
REQ-019 When readEn=1, readData SHALL be captured into the shift register at that same edge; the byte index SHALL be set to 0 and the state SHALL become SHIFT.
REQ-020 outValid SHALL be 1 iff state==SHIFT.
REQ-021 outData SHALL equal shreg[OutWidth-1:0], which emits beats LSB-first.
REQ-022 outLast SHALL be 1 iff outValid && byteIdx==Ratio-1.
REQ-023 A beat SHALL transfer iff outValid && outReady; on transfer the shift register SHALL shift right by OutWidth and byteIdx SHALL increment.
REQ-024 While outValid && !outReady, outData, outLast and the shift register SHALL hold stable.
REQ-025 On a transfer with outLast=1: wordCnt SHALL increment by 1, wrapping modulo 2^CntWidth.
REQ-026 On a transfer with outLast=1 and readEn=1, the next word SHALL load with zero bubble; with readEn=0 the state SHALL return to IDLE.
REQ-027 Latency from the readEn cycle to the first outValid SHALL be 1 cycle.
REQ-028 Sustained throughput SHALL be one beat per cycle while outReady=1 and empty=0.
REQ-029 Deasserting enable SHALL NOT abort a held word; the word SHALL complete, and no further fetch SHALL occur until enable=1.
REQ-030 byteIdx SHALL be clog2(Ratio) bits wide and SHALL wrap to 0 on every load.
REQ-031 The FIFO pointer advance SHALL rely solely on readEn; the block SHALL NOT buffer more than one word.

Reset
REQ-032 On rst=1 at an edge: state=IDLE, byteIdx=0, shreg=0 and wordCnt=0, so outValid=0, outLast=0, outData=0 and readEn=0.
REQ-033 Reset mid-word SHALL discard the held word without incrementing wordCnt.
REQ-034 After reset deasserts, the first readEn SHALL occur no earlier than the first cycle with rst=0, enable=1 and empty=0.

Verification
REQ-035 Single word, outReady=1: FIFO holds 32'hA1B2C3D4 -> readEn for 1 cycle; outData sequence D4,C3,B2,A1 on 4 consecutive cycles; outLast on A1; wordCnt=1; then IDLE.
REQ-036 Back-to-back: 3 words, outReady=1 -> 12 consecutive beats with no outValid gap; readEn pulses coincide with the outLast transfers; wordCnt=3.
REQ-037 Backpressure: outReady=0 for 5 cycles mid-word -> outData/outLast stable; no readEn; resume -> beats continue in order.
REQ-038 Empty FIFO: empty=1 with enable=1 for 10 cycles -> readEn=0 and outValid=0 throughout; a word then arrives -> readEn asserted the same cycle empty falls.
REQ-039 Reset during beat 2 of 4 -> the next cycle has outValid=0 and wordCnt=0; the remaining beats are never emitted.
REQ-040 Enable drop: enable=0 during beat 1, FIFO non-empty -> the word completes (4 beats); no readEn until enable=1; wordCnt=1 at 16'hFFFF + one word -> 0 (wrap check).
